// File: rtl/tilling_pkg.sv
// tilling_pkg: shared sizing constants and FSM state encoding for tilling_sequencer.
package tilling_pkg;

    localparam int SIZE_OF_INPUT   = 16;
    localparam int SIZE_OF_FEATURE = 4;
    localparam int NUM_CORE        = 4;
    localparam int IDX_W           = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/tilling_credit_counter.sv
// tilling_credit_counter: counts issued groups not yet returned by tilling_machine.
// A simultaneous issue and return leaves the count unchanged; a lone return at zero is flagged.
module tilling_credit_counter
    import tilling_pkg::*;
#(
    parameter int MAX_INFLIGHT = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic has_credit_o,
    output logic empty_o,
    output logic underflow_o
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d     = count_q;
        underflow_o = 1'b0;
        if (inc_i && !dec_i) begin
            count_d = count_q + 1'b1;
        end else if (dec_i && !inc_i) begin
            if (count_q == '0) begin
                underflow_o = 1'b1;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign has_credit_o = (count_q < CW'(MAX_INFLIGHT));
    assign empty_o      = (count_q == '0);

endmodule

// File: rtl/tilling_sequencer.sv
// tilling_sequencer: gathers one column per core, issues aligned groups to tilling_machine
// under credit control, and walks a row x column tile grid. Optional: TILLING_TIMEOUT_EN.
module tilling_sequencer #(
    parameter int SIZE_OF_INPUT  = tilling_pkg::SIZE_OF_INPUT,
    parameter int NUM_CORE       = tilling_pkg::NUM_CORE,
`ifdef TILLING_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 64,
`endif
    parameter int MAX_INFLIGHT   = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic [tilling_pkg::IDX_W-1:0]     cfg_num_col_i,
    input  logic [tilling_pkg::IDX_W-1:0]     cfg_num_row_i,
    input  logic [SIZE_OF_INPUT*NUM_CORE-1:0] core_data_i,
    input  logic [NUM_CORE-1:0]               core_valid_i,
    output logic [NUM_CORE-1:0]               core_ready_o,
    output logic [SIZE_OF_INPUT*NUM_CORE-1:0] overlapped_column_core_o,
    output logic [NUM_CORE-1:0]               valid_data_core_o,
    input  logic                              tm_valid_i,
    output logic [tilling_pkg::IDX_W-1:0]     col_idx_o,
    output logic [tilling_pkg::IDX_W-1:0]     row_idx_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              protocol_err_o
);
    import tilling_pkg::*;

    localparam int DW = SIZE_OF_INPUT * NUM_CORE;

    state_t             state_q;
    logic [IDX_W-1:0]   cfg_col_q, cfg_row_q;
    logic [IDX_W-1:0]   col_q, row_q;
    logic [NUM_CORE-1:0] held_q, valid_q;
    logic [DW-1:0]      buf_q, data_q, masked;
    logic               done_q, err_q;
    logic               has_credit, empty, underflow;
    logic               issue_go, last_group;
    logic [NUM_CORE-1:0] take;

`ifdef TILLING_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;
    logic          tmo_hit;

    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES));

    // Counts only while a group is partially filled; any other situation restarts it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_q <= '0;
        end else if (state_q != ST_COLLECT || held_q == '0 || (&held_q)) begin
            tmo_q <= '0;
        end else if (!tmo_hit) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    assign issue_go = (state_q == ST_COLLECT) && ((&held_q) || tmo_hit) && has_credit;
`else
    assign issue_go = (state_q == ST_COLLECT) && (&held_q) && has_credit;
`endif

    // Ready is withheld on the deciding cycle so a late lane is never lost to the held clear.
    assign core_ready_o = (state_q == ST_COLLECT && !issue_go) ? ~held_q : '0;
    assign take         = core_valid_i & core_ready_o;
    assign last_group   = (col_q == cfg_col_q - IDX_W'(1)) && (row_q == cfg_row_q - IDX_W'(1));

    always_comb begin
        masked = '0;
        for (int k = 0; k < NUM_CORE; k++) begin
            if (held_q[k]) begin
                masked[k*SIZE_OF_INPUT +: SIZE_OF_INPUT] = buf_q[k*SIZE_OF_INPUT +: SIZE_OF_INPUT];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            held_q <= '0;
            buf_q  <= '0;
        end else if (state_q == ST_ISSUE) begin
            held_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CORE; k++) begin
                if (take[k]) begin
                    held_q[k] <= 1'b1;
                    buf_q[k*SIZE_OF_INPUT +: SIZE_OF_INPUT] <= core_data_i[k*SIZE_OF_INPUT +: SIZE_OF_INPUT];
                end
            end
        end
    end

    tilling_credit_counter #(
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_credit (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .inc_i        (state_q == ST_ISSUE),
        .dec_i        (tm_valid_i),
        .has_credit_o (has_credit),
        .empty_o      (empty),
        .underflow_o  (underflow)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cfg_col_q <= '0;
            cfg_row_q <= '0;
            col_q     <= '0;
            row_q     <= '0;
            valid_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            valid_q <= '0;
            done_q  <= (state_q == ST_DONE);
            if (underflow) begin
                err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        cfg_col_q <= cfg_num_col_i;
                        cfg_row_q <= cfg_num_row_i;
                        col_q     <= '0;
                        row_q     <= '0;
                        state_q   <= (cfg_num_col_i == '0 || cfg_num_row_i == '0) ? ST_DONE : ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (issue_go) begin
                        valid_q <= held_q;
                        data_q  <= masked;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Both indices wrap at cfg-1, so 255x255 never overflows the 8-bit counters.
                    if (col_q == cfg_col_q - IDX_W'(1)) begin
                        col_q <= '0;
                        row_q <= (row_q == cfg_row_q - IDX_W'(1)) ? '0 : row_q + IDX_W'(1);
                    end else begin
                        col_q <= col_q + IDX_W'(1);
                    end
                    state_q <= last_group ? ST_DRAIN : ST_COLLECT;
                end
                ST_DRAIN: begin
                    if (empty) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign overlapped_column_core_o = data_q;
    assign valid_data_core_o        = valid_q;
    assign col_idx_o                = col_q;
    assign row_idx_o                = row_q;
    assign busy_o                   = (state_q != ST_IDLE);
    assign done_o                   = done_q;
    assign protocol_err_o           = err_q;

endmodule

// File: tb/tb_tilling_sequencer.sv
// tb_tilling_sequencer: directed table and hand-written sequences for tilling_sequencer.
`timescale 1ns/1ps
module tb_tilling_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [7:0]  cfg_num_col_i, cfg_num_row_i;
    logic [63:0] core_data_i;
    logic [3:0]  core_valid_i;
    logic [3:0]  core_ready_o;
    logic [63:0] overlapped_column_core_o;
    logic [3:0]  valid_data_core_o;
    logic        tm_valid_i;
    logic [7:0]  col_idx_o, row_idx_o;
    logic        busy_o, done_o, protocol_err_o;

    int checks = 0;
    int errors = 0;
    int pend   = 0;

    always #5 clk_i = ~clk_i;

`ifdef TILLING_TIMEOUT_EN
    tilling_sequencer #(.TIMEOUT_CYCLES(8)) dut (
`else
    tilling_sequencer dut (
`endif
        .clk_i                    (clk_i),
        .rst_i                    (rst_i),
        .start_i                  (start_i),
        .cfg_num_col_i            (cfg_num_col_i),
        .cfg_num_row_i            (cfg_num_row_i),
        .core_data_i              (core_data_i),
        .core_valid_i             (core_valid_i),
        .core_ready_o             (core_ready_o),
        .overlapped_column_core_o (overlapped_column_core_o),
        .valid_data_core_o        (valid_data_core_o),
        .tm_valid_i               (tm_valid_i),
        .col_idx_o                (col_idx_o),
        .row_idx_o                (row_idx_o),
        .busy_o                   (busy_o),
        .done_o                   (done_o),
        .protocol_err_o           (protocol_err_o)
    );

    typedef struct {
        logic        st;
        logic [7:0]  cc, cr;
        logic [3:0]  cv;
        logic        tmv;
        logic [3:0]  rdy, vld;
        logic        bsy, dn;
        logic [7:0]  row, col;
        logic [63:0] dat;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    function automatic logic [63:0] mkd(input int i);
        logic [63:0] d;
        for (int k = 0; k < 4; k++) d[k*16 +: 16] = 16'(i * 256 + k);
        return d;
    endfunction

    function automatic vec_t V(input logic st, input logic [3:0] cv, input logic tmv,
                               input logic [3:0] rdy, input logic [3:0] vld, input logic bsy,
                               input logic dn, input logic [7:0] row, input logic [7:0] col,
                               input logic [63:0] dat);
        vec_t v;
        v.st = st; v.cc = 8'd2; v.cr = 8'd2; v.cv = cv; v.tmv = tmv;
        v.rdy = rdy; v.vld = vld; v.bsy = bsy; v.dn = dn; v.row = row; v.col = col; v.dat = dat;
        return v;
    endfunction

    task automatic start_frame(input logic [7:0] c, input logic [7:0] r);
        start_i = 1'b1; cfg_num_col_i = c; cfg_num_row_i = r;
        step();
        start_i = 1'b0;
    endtask

    // Returns credits as the bench sees beats, never pulsing tm_valid_i with nothing outstanding.
    task automatic run_frame(input int budget, output int beats, output logic dn,
                             output logic [63:0] ldat, output logic [7:0] lrow, output logic [7:0] lcol);
        beats = 0; dn = 1'b0; ldat = '0; lrow = '0; lcol = '0;
        for (int s = 0; s < budget && !dn; s++) begin
            core_valid_i = 4'hF;
            tm_valid_i   = (pend > 0);
            if (pend > 0) pend--;
            step();
            if (valid_data_core_o != 4'h0) begin
                beats++; pend++;
                ldat = overlapped_column_core_o; lrow = row_idx_o; lcol = col_idx_o;
            end
            if (done_o) dn = 1'b1;
        end
        core_valid_i = 4'h0;
        tm_valid_i   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int          beats;
        logic        dn;
        logic [63:0] ldat, expd;
        logic [7:0]  lrow, lcol;
        logic [3:0]  held, exp_rdy;
        logic        got;

        rst_i = 1'b1; start_i = 1'b0; cfg_num_col_i = '0; cfg_num_row_i = '0;
        core_data_i = '0; core_valid_i = '0; tm_valid_i = 1'b0;
        @(negedge clk_i); @(negedge clk_i);
        chk("rst busy", 64'(busy_o), 64'(0));
        chk("rst done", 64'(done_o), 64'(0));
        chk("rst ready", 64'(core_ready_o), 64'(0));
        chk("rst valid", 64'(valid_data_core_o), 64'(0));
        chk("rst data", overlapped_column_core_o, 64'(0));
        chk("rst err", 64'(protocol_err_o), 64'(0));
        chk("rst idx", 64'({row_idx_o, col_idx_o}), 64'(0));
        rst_i = 1'b0;
        step();

        // Basic 2x2 frame: every core valid each cycle, credits returned 3 cycles after each beat.
        tbl[0]  = V(1, 4'h0, 0, 4'hF, 4'h0, 1, 0, 0, 0, 64'(0));
        tbl[1]  = V(0, 4'hF, 0, 4'h0, 4'h0, 1, 0, 0, 0, 64'(0));
        tbl[2]  = V(0, 4'hF, 0, 4'h0, 4'hF, 1, 0, 0, 0, mkd(1));
        tbl[3]  = V(0, 4'hF, 0, 4'hF, 4'h0, 1, 0, 0, 1, mkd(1));
        tbl[4]  = V(0, 4'hF, 0, 4'h0, 4'h0, 1, 0, 0, 1, mkd(1));
        tbl[5]  = V(0, 4'hF, 1, 4'h0, 4'hF, 1, 0, 0, 1, mkd(4));
        tbl[6]  = V(0, 4'hF, 0, 4'hF, 4'h0, 1, 0, 1, 0, mkd(4));
        tbl[7]  = V(0, 4'hF, 0, 4'h0, 4'h0, 1, 0, 1, 0, mkd(4));
        tbl[8]  = V(0, 4'hF, 1, 4'h0, 4'hF, 1, 0, 1, 0, mkd(7));
        tbl[9]  = V(0, 4'hF, 0, 4'hF, 4'h0, 1, 0, 1, 1, mkd(7));
        tbl[10] = V(0, 4'hF, 0, 4'h0, 4'h0, 1, 0, 1, 1, mkd(7));
        tbl[11] = V(0, 4'hF, 1, 4'h0, 4'hF, 1, 0, 1, 1, mkd(10));
        tbl[12] = V(0, 4'h0, 0, 4'h0, 4'h0, 1, 0, 0, 0, mkd(10));
        tbl[13] = V(0, 4'h0, 0, 4'h0, 4'h0, 1, 0, 0, 0, mkd(10));
        tbl[14] = V(0, 4'h0, 1, 4'h0, 4'h0, 1, 0, 0, 0, mkd(10));
        tbl[15] = V(0, 4'h0, 0, 4'h0, 4'h0, 1, 0, 0, 0, mkd(10));
        tbl[16] = V(0, 4'h0, 0, 4'h0, 4'h0, 0, 1, 0, 0, mkd(10));
        tbl[17] = V(0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0, 0, mkd(10));
        for (int i = 0; i < 18; i++) begin
            start_i = tbl[i].st; cfg_num_col_i = tbl[i].cc; cfg_num_row_i = tbl[i].cr;
            core_valid_i = tbl[i].cv; tm_valid_i = tbl[i].tmv; core_data_i = mkd(i);
            step();
            chk($sformatf("basic[%0d] ready", i), 64'(core_ready_o), 64'(tbl[i].rdy));
            chk($sformatf("basic[%0d] valid", i), 64'(valid_data_core_o), 64'(tbl[i].vld));
            chk($sformatf("basic[%0d] busy", i), 64'(busy_o), 64'(tbl[i].bsy));
            chk($sformatf("basic[%0d] done", i), 64'(done_o), 64'(tbl[i].dn));
            chk($sformatf("basic[%0d] row", i), 64'(row_idx_o), 64'(tbl[i].row));
            chk($sformatf("basic[%0d] col", i), 64'(col_idx_o), 64'(tbl[i].col));
            chk($sformatf("basic[%0d] data", i), overlapped_column_core_o, tbl[i].dat);
        end
        start_i = 1'b0; core_valid_i = '0; tm_valid_i = 1'b0;

`ifndef TILLING_TIMEOUT_EN
        // Staggered lanes on a 1x1 frame; lane 0 re-asserts with new data before the issue.
        begin
            int hs[4];
            hs[0] = 0; hs[1] = 3; hs[2] = 5; hs[3] = 9;
            expd = {16'h4009, 16'h3005, 16'h2003, 16'h1000};
            held = '0;
            start_frame(8'd1, 8'd1);
            for (int j = 0; j < 14; j++) begin
                core_valid_i = '0;
                for (int k = 0; k < 4; k++) begin
                    if (hs[k] == j) begin
                        core_valid_i[k] = 1'b1;
                        core_data_i[k*16 +: 16] = 16'(16'h1000 * (k + 1) + j);
                    end
                end
                if (j == 4) begin
                    core_valid_i[0] = 1'b1;
                    core_data_i[15:0] = 16'hBAD0;
                end
                step();
                for (int k = 0; k < 4; k++) if (hs[k] <= j) held[k] = 1'b1;
                exp_rdy = ~held;
                if (j <= 9) chk($sformatf("stagger[%0d] ready", j), 64'(core_ready_o), 64'(exp_rdy));
                chk($sformatf("stagger[%0d] valid", j), 64'(valid_data_core_o), (j == 10) ? 64'hF : 64'h0);
                if (j == 10) chk("stagger data", overlapped_column_core_o, expd);
            end
            core_valid_i = '0;
            pend = 1;
            run_frame(20, beats, dn, ldat, lrow, lcol);
            chk("stagger done", 64'(dn), 64'(1));
            chk("stagger extra beats", 64'(beats), 64'(0));
        end
`endif

        // Credit stall on a 1x4 frame with no returns.
        pend = 0; beats = 0;
        core_data_i = mkd(50);
        start_frame(8'd4, 8'd1);
        for (int s = 0; s < 15; s++) begin
            core_valid_i = 4'hF; tm_valid_i = 1'b0;
            step();
            if (valid_data_core_o != 4'h0) begin beats++; pend++; end
        end
        chk("stall beats", 64'(beats), 64'(2));
        chk("stall ready", 64'(core_ready_o), 64'(0));
        tm_valid_i = 1'b1; pend--;
        step();
        tm_valid_i = 1'b0;
        got = 1'b0;
        for (int s = 0; s < 5 && !got; s++) begin
            step();
            if (valid_data_core_o != 4'h0) begin
                got = 1'b1; pend++;
                chk("stall 3rd col", 64'(col_idx_o), 64'(2));
            end
        end
        chk("stall 3rd beat", 64'(got), 64'(1));
        run_frame(40, beats, dn, ldat, lrow, lcol);
        chk("stall 4th beat", 64'(beats), 64'(1));
        chk("stall done", 64'(dn), 64'(1));

        // Zero column count: no beats, done two cycles after start.
        start_i = 1'b1; cfg_num_col_i = 8'd0; cfg_num_row_i = 8'd3;
        step();
        start_i = 1'b0;
        chk("cfg0 done early", 64'(done_o), 64'(0));
        step();
        chk("cfg0 done", 64'(done_o), 64'(1));
        chk("cfg0 valid", 64'(valid_data_core_o), 64'(0));
        step();
        chk("cfg0 done once", 64'(done_o), 64'(0));

        // Start while busy is ignored: the 1x1 frame yields exactly one beat.
        start_frame(8'd1, 8'd1);
        start_i = 1'b1; cfg_num_col_i = 8'd5; cfg_num_row_i = 8'd5;
        step();
        start_i = 1'b0;
        chk("busy start", 64'(busy_o), 64'(1));
        run_frame(40, beats, dn, ldat, lrow, lcol);
        chk("busy start beats", 64'(beats), 64'(1));
        chk("busy start done", 64'(dn), 64'(1));

        // Return with nothing outstanding raises a sticky error.
        chk("perr before", 64'(protocol_err_o), 64'(0));
        tm_valid_i = 1'b1;
        step();
        tm_valid_i = 1'b0;
        chk("perr set", 64'(protocol_err_o), 64'(1));
        step(); step(); step();
        chk("perr sticky", 64'(protocol_err_o), 64'(1));

        // Asynchronous reset mid-collect with two lanes held.
        start_frame(8'd2, 8'd2);
        core_valid_i = 4'b0101;
        step();
        core_valid_i = '0;
        chk("abort ready", 64'(core_ready_o), 64'(4'b1010));
        #2 rst_i = 1'b1;
        #1;
        chk("abort busy", 64'(busy_o), 64'(0));
        chk("abort ready0", 64'(core_ready_o), 64'(0));
        chk("abort data", overlapped_column_core_o, 64'(0));
        chk("abort err", 64'(protocol_err_o), 64'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
        pend = 0;
        core_data_i = 64'h0123_4567_89AB_CDEF;
        start_frame(8'd1, 8'd1);
        run_frame(40, beats, dn, ldat, lrow, lcol);
        chk("clean beats", 64'(beats), 64'(1));
        chk("clean data", ldat, 64'h0123_4567_89AB_CDEF);
        chk("clean idx", 64'({lrow, lcol}), 64'(0));
        chk("clean done", 64'(dn), 64'(1));

`ifdef TILLING_TIMEOUT_EN
        // Only lanes 0 and 2 respond: a partial group issues after the timeout.
        pend = 0;
        start_frame(8'd1, 8'd1);
        core_data_i = {16'hFFFF, 16'h00CC, 16'hFFFF, 16'h00AA};
        core_valid_i = 4'b0101;
        step();
        core_valid_i = '0;
        got = 1'b0;
        for (int s = 0; s < 20 && !got; s++) begin
            step();
            if (valid_data_core_o != 4'h0) begin
                got = 1'b1; pend++;
                chk("tmo valid", 64'(valid_data_core_o), 64'(4'b0101));
                chk("tmo data", overlapped_column_core_o, 64'h0000_00CC_0000_00AA);
            end
        end
        chk("tmo beat", 64'(got), 64'(1));
        run_frame(40, beats, dn, ldat, lrow, lcol);
        chk("tmo done", 64'(dn), 64'(1));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
